mux_step_bank: RTL and testbench

Parametrised, registered successor to the dual 1-of-4 mux: CHANS parallel channels, each selecting one of INPUTS data bits through a shared select register that can be loaded, stepped (auto-increment with wrap) or cleared. The outputs are registered and hold their last value while disabled, so no latches are inferred. It is used wherever a datapath scans a field across several sources on successive cycles, such as shift-count, byte-pointer and diagnostic readback paths.

---
 rtl/kl_mux_pkg.sv | 26 ++
 rtl/mux_sel_ctr.sv | 85 ++++++++
 rtl/mux_step_bank.sv | 78 +++++++
 tb/tb_mux_step_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kl_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kl_mux_pkg
//  Purpose  : Shared types and helpers for the stepping select mux bank.
//             Holds the select-register operation encoding and the wrap test.
//  Revision : 1.0  initial release
// ============================================================================
package kl_mux_pkg;

    // Operation applied to the select register on one edge, after priority
    // resolution of the CLR / SEL_LOAD / STEP request lines.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_CLR  = 2'd1,
        SEL_LOAD = 2'd2,
        SEL_STEP = 2'd3
    } sel_op_t;

    // True when a select value sits at the last legal input, so the next
    // step must wrap back to zero instead of incrementing.
    function automatic logic sel_wrap(input int sel, input int inputs);
        return (sel == (inputs - 1));
    endfunction

endpackage : kl_mux_pkg
`default_nettype wire

// File: rtl/mux_sel_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_sel_ctr
//  Purpose  : Select register shared by all mux channels. Supports clear,
//             load (with range check) and auto-increment with wrap, and
//             emits one-cycle WRAP / SEL_ERR pulses.
//  Revision : 1.0  initial release
// ============================================================================
module mux_sel_ctr
    import kl_mux_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int SELW   = $clog2(INPUTS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [SELW-1:0] load_val,
    input  logic            step,
    output logic [SELW-1:0] sel,
    output logic            wrap,
    output logic            sel_err
);

    sel_op_t         op;
    logic            load_ok;
    logic            at_last;
    logic [SELW-1:0] sel_inc;

    // Resolve the request lines into one operation: clear beats load beats step.
    always_comb begin
        op = SEL_HOLD;
        if (clr) begin
            op = SEL_CLR;
        end else if (load) begin
            op = SEL_LOAD;
        end else if (step) begin
            op = SEL_STEP;
        end
    end

    // A load is only accepted when it names an existing input; this keeps the
    // register inside 0..INPUTS-1 even when INPUTS is not a power of two.
    assign load_ok = (int'(load_val) < INPUTS);
    assign at_last = sel_wrap(int'(sel), INPUTS);
    assign sel_inc = sel + SELW'(1);

    // Select register plus the two status pulses, which default low every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            sel_err <= 1'b0;
            case (op)
                SEL_CLR: begin
                    sel <= '0;
                end
                SEL_LOAD: begin
                    if (load_ok) begin
                        sel <= load_val;
                    end else begin
                        sel_err <= 1'b1;
                    end
                end
                SEL_STEP: begin
                    if (at_last) begin
                        sel  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        sel  <= sel_inc;
                    end
                end
                default: begin
                    sel <= sel;
                end
            endcase
        end
    end

endmodule : mux_sel_ctr
`default_nettype wire

// File: rtl/mux_step_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mux_step_bank
//  Purpose  : CHANS parallel 1-of-INPUTS muxes sharing one steppable select
//             register, each feeding a registered output that holds while
//             capture is disabled. All outputs are flop-driven.
//  Revision : 1.0  initial release
// ============================================================================
module mux_step_bank #(
    parameter int CHANS  = 2,
    parameter int INPUTS = 4,
    parameter int SELW   = $clog2(INPUTS)
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           CLR,
    input  logic                           SEL_LOAD,
    input  logic [SELW-1:0]                SEL_IN,
    input  logic                           STEP,
    input  logic                           EN,
    input  logic [CHANS-1:0][INPUTS-1:0]   D,
    output logic [CHANS-1:0]               Q,
    output logic                           VALID,
    output logic [SELW-1:0]                SEL,
    output logic                           WRAP,
    output logic                           SEL_ERR
);

    // The select register is the only shared state; every channel indexes
    // its data with the pre-edge value, so a capture and a step on the same
    // edge see the old select.
    mux_sel_ctr #(
        .INPUTS (INPUTS),
        .SELW   (SELW)
    ) u_sel_ctr (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .clr      (CLR),
        .load     (SEL_LOAD),
        .load_val (SEL_IN),
        .step     (STEP),
        .sel      (SEL),
        .wrap     (WRAP),
        .sel_err  (SEL_ERR)
    );

    generate
        for (genvar c = 0; c < CHANS; c++) begin : g_chan
            logic pick;
            logic q_bit;

            // SEL is always below INPUTS, so this index never leaves the vector.
            assign pick = D[c][SEL];

            // Output flop for this channel: capture on EN, otherwise hold.
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    q_bit <= 1'b0;
                end else if (EN) begin
                    q_bit <= pick;
                end
            end

            assign Q[c] = q_bit;
        end
    endgenerate

    // VALID marks that Q was refreshed on the most recent edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            VALID <= 1'b0;
        end else begin
            VALID <= EN;
        end
    end

endmodule : mux_step_bank
`default_nettype wire

// File: tb/tb_mux_step_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_step_bank
//  Purpose  : Directed self-checking bench for mux_step_bank: a default
//             instance (CHANS=2, INPUTS=4) and a non-power-of-two instance
//             (CHANS=1, INPUTS=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_step_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Default instance signals
    logic             a_clr = 1'b0, a_load = 1'b0, a_step = 1'b0, a_en = 1'b0;
    logic [1:0]       a_sel_in = '0;
    logic [1:0][3:0]  a_d = '0;
    logic [1:0]       a_q;
    logic             a_valid, a_wrap, a_err;
    logic [1:0]       a_sel;

    // INPUTS=3 instance signals
    logic             b_clr = 1'b0, b_load = 1'b0, b_step = 1'b0, b_en = 1'b0;
    logic [1:0]       b_sel_in = '0;
    logic [0:0][2:0]  b_d = '0;
    logic [0:0]       b_q;
    logic             b_valid, b_wrap, b_err;
    logic [1:0]       b_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_step_bank #(.CHANS(2), .INPUTS(4)) u_dut_a (
        .CLK(clk), .RESET_N(rst_n), .CLR(a_clr), .SEL_LOAD(a_load),
        .SEL_IN(a_sel_in), .STEP(a_step), .EN(a_en), .D(a_d),
        .Q(a_q), .VALID(a_valid), .SEL(a_sel), .WRAP(a_wrap), .SEL_ERR(a_err)
    );

    mux_step_bank #(.CHANS(1), .INPUTS(3)) u_dut_b (
        .CLK(clk), .RESET_N(rst_n), .CLR(b_clr), .SEL_LOAD(b_load),
        .SEL_IN(b_sel_in), .STEP(b_step), .EN(b_en), .D(b_d),
        .Q(b_q), .VALID(b_valid), .SEL(b_sel), .WRAP(b_wrap), .SEL_ERR(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset held ----------------
        #2;
        check("rst_a_sel",   32'(a_sel),   32'd0);
        check("rst_a_q",     32'(a_q),     32'd0);
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_sel",   32'(b_sel),   32'd0);
        tick();
        check("rst_hold_a_q", 32'(a_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- idle after release ----------------
        tick();
        tick();
        check("idle_a_sel",   32'(a_sel),   32'd0);
        check("idle_a_q",     32'(a_q),     32'd0);
        check("idle_a_valid", 32'(a_valid), 32'd0);
        check("idle_a_wrap",  32'(a_wrap),  32'd0);
        check("idle_a_err",   32'(a_err),   32'd0);

        // ---------------- scan, default instance ----------------
        // D[0]=1010, D[1]=0110. Pre-edge SEL 0,1,2,3,0 gives {Q1,Q0} = 00,11,10,01,00.
        a_d    = {4'b0110, 4'b1010};
        a_step = 1'b1;
        a_en   = 1'b1;
        tick();
        check("scan1_q", 32'(a_q), 32'b00); check("scan1_sel", 32'(a_sel), 32'd1);
        check("scan1_wrap", 32'(a_wrap), 32'd0); check("scan1_valid", 32'(a_valid), 32'd1);
        tick();
        check("scan2_q", 32'(a_q), 32'b11); check("scan2_sel", 32'(a_sel), 32'd2);
        check("scan2_wrap", 32'(a_wrap), 32'd0);
        tick();
        check("scan3_q", 32'(a_q), 32'b10); check("scan3_sel", 32'(a_sel), 32'd3);
        check("scan3_wrap", 32'(a_wrap), 32'd0);
        tick();
        check("scan4_q", 32'(a_q), 32'b01); check("scan4_sel", 32'(a_sel), 32'd0);
        check("scan4_wrap", 32'(a_wrap), 32'd1);
        tick();
        check("scan5_q", 32'(a_q), 32'b00); check("scan5_sel", 32'(a_sel), 32'd1);
        check("scan5_wrap", 32'(a_wrap), 32'd0);
        a_step = 1'b0;
        a_en   = 1'b0;

        // ---------------- INPUTS=3 instance ----------------
        // D=3'b110; pre-edge SEL 0,1,2,0 gives Q 0,1,1,0; SEL 1,2,0,1; wrap on 3rd.
        b_d    = 3'b110;
        b_step = 1'b1;
        b_en   = 1'b1;
        tick();
        check("b_s1_sel", 32'(b_sel), 32'd1); check("b_s1_wrap", 32'(b_wrap), 32'd0);
        check("b_s1_q", 32'(b_q), 32'd0);
        tick();
        check("b_s2_sel", 32'(b_sel), 32'd2); check("b_s2_wrap", 32'(b_wrap), 32'd0);
        check("b_s2_q", 32'(b_q), 32'd1);
        tick();
        check("b_s3_sel", 32'(b_sel), 32'd0); check("b_s3_wrap", 32'(b_wrap), 32'd1);
        check("b_s3_q", 32'(b_q), 32'd1);
        tick();
        check("b_s4_sel", 32'(b_sel), 32'd1); check("b_s4_wrap", 32'(b_wrap), 32'd0);
        check("b_s4_q", 32'(b_q), 32'd0);
        b_step = 1'b0;
        b_en   = 1'b0;
        // Out-of-range load: SEL stays 1, SEL_ERR pulses for one cycle.
        b_load   = 1'b1;
        b_sel_in = 2'd3;
        tick();
        check("b_bad_sel", 32'(b_sel), 32'd1);
        check("b_bad_err", 32'(b_err), 32'd1);
        b_load = 1'b0;
        tick();
        check("b_err_clear", 32'(b_err), 32'd0);
        check("b_hold_sel",  32'(b_sel), 32'd1);
        // Legal load of the top input.
        b_load   = 1'b1;
        b_sel_in = 2'd2;
        tick();
        check("b_ld2_sel", 32'(b_sel), 32'd2);
        check("b_ld2_err", 32'(b_err), 32'd0);
        b_load = 1'b0;

        // ---------------- priority, default instance ----------------
        a_clr    = 1'b1;
        a_load   = 1'b1;
        a_sel_in = 2'd2;
        a_step   = 1'b1;
        tick();
        check("prio_clr_sel",  32'(a_sel),  32'd0);
        check("prio_clr_wrap", 32'(a_wrap), 32'd0);
        a_clr = 1'b0;
        tick();
        check("prio_load_sel", 32'(a_sel), 32'd2);
        a_load = 1'b0;
        a_step = 1'b0;

        // ---------------- hold while disabled ----------------
        a_load   = 1'b1;
        a_sel_in = 2'd1;
        tick();
        check("hold_ld_sel", 32'(a_sel), 32'd1);
        a_load = 1'b0;
        a_en   = 1'b1;
        tick();
        check("hold_cap_q",     32'(a_q),     32'b11);
        check("hold_cap_valid", 32'(a_valid), 32'd1);
        a_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_d = ~a_d;
            tick();
            check("hold_q",     32'(a_q),     32'b11);
            check("hold_valid", 32'(a_valid), 32'd0);
        end

        // ---------------- async reset mid-scan ----------------
        a_d      = {4'b0110, 4'b1010};
        a_load   = 1'b1;
        a_sel_in = 2'd2;
        tick();
        a_load = 1'b0;
        a_en   = 1'b1;
        tick();
        check("ar_pre_sel", 32'(a_sel), 32'd2);
        check("ar_pre_q",   32'(a_q),   32'b10);
        a_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sel",   32'(a_sel),   32'd0);
        check("ar_q",     32'(a_q),     32'd0);
        check("ar_valid", 32'(a_valid), 32'd0);
        check("ar_b_sel", 32'(b_sel),   32'd0);
        a_step = 1'b1;
        tick();
        check("ar_held_sel", 32'(a_sel), 32'd0);
        a_step = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_ar_sel",  32'(a_sel),  32'd0);
        check("post_ar_wrap", 32'(a_wrap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_step_bank
`default_nettype wire
